// File: rtl/byte_pkg.sv
// Shared types and frame constants for the byte serial transmitter.
package byte_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam int FRAME_BITS = 10;
  localparam int DATA_BITS  = 8;

endpackage

// File: rtl/bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
module bit_timer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic bit_end
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] count_r;

  // Bit-period counter, restarted on frame accept and wrapped at each bit boundary.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_r <= {CW{1'b0}};
    end else if (clear) begin
      count_r <= {CW{1'b0}};
    end else if (enable) begin
      if (count_r == LAST_COUNT) begin
        count_r <= {CW{1'b0}};
      end else begin
        count_r <= count_r + CW'(1);
      end
    end else begin
      count_r <= count_r;
    end
  end

  assign bit_end = enable && (count_r == LAST_COUNT);

endmodule

// File: rtl/byte_serial_tx.sv
// Start/8N/stop serial transmitter with valid/ready byte intake and a done pulse.
module byte_serial_tx
  import byte_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] data,
  input  logic       send,
  output logic       ready,
  output logic       tx,
  output logic       done
);

  localparam logic [2:0] LAST_INDEX = 3'(DATA_BITS - 1);

  tx_state_t              state_r;
  logic [DATA_BITS-1:0]   shreg_r;
  logic [2:0]             index_r;
  logic                   tx_r;
  logic                   ready_r;
  logic                   done_r;
  logic                   accept_s;
  logic                   timer_en_s;
  logic                   bit_end_s;

  assign accept_s   = ready_r && send;
  assign timer_en_s = (state_r != IDLE);

  bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_bit_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (accept_s),
    .enable  (timer_en_s),
    .bit_end (bit_end_s)
  );

  // Frame sequencer; tx is loaded one edge ahead so the line changes exactly on bit boundaries.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
      shreg_r <= {DATA_BITS{1'b0}};
      index_r <= 3'd0;
      tx_r    <= 1'b1;
      ready_r <= 1'b1;
      done_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (send) begin
            shreg_r <= data;
            index_r <= 3'd0;
            tx_r    <= 1'b0;
            ready_r <= 1'b0;
            state_r <= START;
          end
        end
        START: begin
          if (bit_end_s) begin
            tx_r    <= shreg_r[0];
            state_r <= DATA;
          end
        end
        DATA: begin
          if (bit_end_s) begin
            if (index_r == LAST_INDEX) begin
              tx_r    <= 1'b1;
              state_r <= STOP;
            end else begin
              shreg_r <= {1'b0, shreg_r[DATA_BITS-1:1]};
              index_r <= index_r + 3'd1;
              tx_r    <= shreg_r[1];
            end
          end
        end
        STOP: begin
          if (bit_end_s) begin
            ready_r <= 1'b1;
            done_r  <= 1'b1;
            state_r <= IDLE;
          end
        end
        default: begin
          tx_r    <= 1'b1;
          ready_r <= 1'b1;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign tx    = tx_r;
  assign ready = ready_r;
  assign done  = done_r;

endmodule
